// File: rtl/mem_pkg.sv
// Shared memory-side types for the L1/L2 port arbiter: FSM states, requester ids, line sizing.
package mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  function automatic int line_bits(input int line_size);
    return line_size * 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. On a tie the requester not named by i_last_grant wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic    [1:0] i_req,
  input  req_id_t       i_last_grant,
  output logic    [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11)
      o_grant = (i_last_grant == REQ_DC) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request/response port between the I$ refill and D$ refill/writeback paths.
// One L2 transaction in flight at a time; round-robin grant, each transaction runs to completion.
module l2_port_arbiter
  import mem_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_SIZE  = 64,
  localparam int LW         = line_bits(LINE_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
  output logic                  ic_resp_valid_o,
  input  logic                  ic_resp_ready_i,
  output logic [LW-1:0]         ic_resp_data_o,
  input  logic                  ic_kill_i,

  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic                  dc_req_we_i,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
  input  logic [LW-1:0]         dc_req_wdata_i,
  output logic                  dc_resp_valid_o,
  input  logic                  dc_resp_ready_i,
  output logic [LW-1:0]         dc_resp_data_o,

  output logic                  l2_req_valid_o,
  input  logic                  l2_req_ready_i,
  output logic                  l2_req_we_o,
  output logic [ADDR_WIDTH-1:0] l2_req_addr_o,
  output logic [LW-1:0]         l2_req_wdata_o,
  input  logic                  l2_resp_valid_i,
  output logic                  l2_resp_ready_o,
  input  logic [LW-1:0]         l2_resp_data_i,

  output logic                  busy_o,
  output logic                  owner_o
);

  arb_state_t            r_state;
  req_id_t               r_owner;
  req_id_t               r_last_grant;
  logic                  r_drop;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LW-1:0]         r_wdata;
  logic [LW-1:0]         r_rdata;

  logic [1:0] w_grant;
  logic       w_ic_acc;
  logic       w_dc_acc;
  logic       w_ic_kill;
  logic       w_owner_rdy;

  rr_arb2 u_rr_arb2 (
    .i_req        ({dc_req_valid_i, ic_req_valid_i}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign ic_req_ready_o  = (r_state == ARB_IDLE) && w_grant[0];
  assign dc_req_ready_o  = (r_state == ARB_IDLE) && w_grant[1];
  assign w_ic_acc        = ic_req_valid_i && ic_req_ready_o;
  assign w_dc_acc        = dc_req_valid_i && dc_req_ready_o;
  // A kill only matters while the I$ owns the port; D$ traffic is immune.
  assign w_ic_kill       = ic_kill_i && (r_owner == REQ_IC);
  assign w_owner_rdy     = (r_owner == REQ_IC) ? ic_resp_ready_i : dc_resp_ready_i;

  assign l2_req_valid_o  = (r_state == ARB_ISSUE);
  assign l2_req_we_o     = r_we;
  assign l2_req_addr_o   = r_addr;
  assign l2_req_wdata_o  = r_wdata;
  assign l2_resp_ready_o = (r_state == ARB_WAIT);

  assign ic_resp_valid_o = (r_state == ARB_RESP) && (r_owner == REQ_IC);
  assign dc_resp_valid_o = (r_state == ARB_RESP) && (r_owner == REQ_DC);
  assign ic_resp_data_o  = r_rdata;
  assign dc_resp_data_o  = r_rdata;

  assign busy_o          = (r_state != ARB_IDLE);
  assign owner_o         = r_owner;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_owner      <= REQ_IC;
      r_last_grant <= REQ_DC;
      r_drop       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_drop <= 1'b0;
          if (w_ic_acc || w_dc_acc) begin
            r_owner      <= req_id_t'(w_dc_acc);
            r_last_grant <= req_id_t'(w_dc_acc);
            r_we         <= w_dc_acc && dc_req_we_i;
            r_addr       <= w_dc_acc ? dc_req_addr_i : ic_req_addr_i;
            r_wdata      <= w_dc_acc ? dc_req_wdata_i : '0;
            r_state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (w_ic_kill) r_drop <= 1'b1;
          if (l2_req_ready_i) r_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // The L2 response is always consumed, even when dropped, so L2 never sees an orphan.
          if (w_ic_kill) r_drop <= 1'b1;
          if (l2_resp_valid_i) begin
            r_rdata <= l2_resp_data_i;
            r_state <= (r_drop || w_ic_kill) ? ARB_IDLE : ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (w_ic_kill || w_owner_rdy) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scenario bench for l2_port_arbiter: expected responses queued at issue, checked when delivered.
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 512;

  typedef struct {
    logic          we;
    logic [LW-1:0] data;
  } dexp_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o, ic_resp_ready_i, ic_kill_i;
  logic [AW-1:0] ic_req_addr_i;
  logic [LW-1:0] ic_resp_data_o;
  logic          dc_req_valid_i, dc_req_ready_o, dc_req_we_i, dc_resp_valid_o, dc_resp_ready_i;
  logic [AW-1:0] dc_req_addr_i;
  logic [LW-1:0] dc_req_wdata_i, dc_resp_data_o;
  logic          l2_req_valid_o, l2_req_ready_i, l2_req_we_o, l2_resp_valid_i, l2_resp_ready_o;
  logic [AW-1:0] l2_req_addr_o;
  logic [LW-1:0] l2_req_wdata_o, l2_resp_data_i;
  logic          busy_o, owner_o;

  logic          l2_fixed_en = 1'b0;
  logic [LW-1:0] l2_fixed    = '0;

  logic [LW-1:0] ic_q[$];
  dexp_t         dc_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  // L2 model: reads return the line address replicated, unless a fixed pattern is selected.
  assign l2_resp_data_i = l2_fixed_en ? l2_fixed : {16{l2_req_addr_o}};

  l2_port_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_req_addr_i(ic_req_addr_i),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_ready_i(ic_resp_ready_i), .ic_resp_data_o(ic_resp_data_o),
    .ic_kill_i(ic_kill_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_req_we_i(dc_req_we_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_wdata_i(dc_req_wdata_i),
    .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_ready_i(dc_resp_ready_i), .dc_resp_data_o(dc_resp_data_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_we_o(l2_req_we_o),
    .l2_req_addr_o(l2_req_addr_o), .l2_req_wdata_o(l2_req_wdata_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_ready_o(l2_resp_ready_o), .l2_resp_data_i(l2_resp_data_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return l2_fixed_en ? l2_fixed : {16{a}};
  endfunction

  // Response monitor: sampled mid-low-phase so handshakes seen here complete at the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst_i) begin
      if (ic_resp_valid_o && dc_resp_valid_o) begin
        n_checks++;
        $display("FAIL resp_exclusive: ic_valid=%b dc_valid=%b, required not both", ic_resp_valid_o, dc_resp_valid_o);
      end
      if (ic_resp_valid_o && ic_resp_ready_i) begin
        n_checks++;
        if (ic_q.size() == 0)
          $display("FAIL ic_resp_unexpected: data=%h, required no response", ic_resp_data_o);
        else begin
          logic [LW-1:0] e;
          e = ic_q.pop_front();
          if (ic_resp_data_o !== e) $display("FAIL ic_resp_data: got %h want %h", ic_resp_data_o, e);
          else n_pass++;
        end
      end
      if (dc_resp_valid_o && dc_resp_ready_i) begin
        n_checks++;
        if (dc_q.size() == 0)
          $display("FAIL dc_resp_unexpected: data=%h, required no response", dc_resp_data_o);
        else begin
          dexp_t e;
          e = dc_q.pop_front();
          if (!e.we && dc_resp_data_o !== e.data) $display("FAIL dc_resp_data: got %h want %h", dc_resp_data_o, e.data);
          else n_pass++;
        end
      end
    end
  end

  task automatic do_reset;
    rst_i = 1'b1;
    ic_req_valid_i = 0; ic_req_addr_i = '0; ic_kill_i = 0; ic_resp_ready_i = 1;
    dc_req_valid_i = 0; dc_req_we_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0; dc_resp_ready_i = 1;
    l2_req_ready_i = 1; l2_resp_valid_i = 1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    #1;
    while ((busy_o || ic_q.size() != 0 || dc_q.size() != 0) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    n_checks++;
    if (n >= 100) $display("FAIL %s_drain: busy=%b ic_q=%0d dc_q=%0d after %0d cycles, required idle and empty", name, busy_o, ic_q.size(), dc_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if ({busy_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o, owner_o} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {busy_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o, owner_o});
    else n_pass++;
    n_checks++;
    if ({l2_req_we_o, l2_req_addr_o, l2_req_wdata_o, ic_resp_data_o} !== '0)
      $display("FAIL reset_data: addr=%h we=%b, required all zero", l2_req_addr_o, l2_req_we_o);
    else n_pass++;
    n_checks++;
    if ({ic_req_ready_o, dc_req_ready_o} !== 2'b00) $display("FAIL reset_ready_idle: got %b want 00", {ic_req_ready_o, dc_req_ready_o});
    else n_pass++;
    ic_req_valid_i = 1; dc_req_valid_i = 1;
    #1;
    n_checks++;
    if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) $display("FAIL reset_tie: got %b want 10", {ic_req_ready_o, dc_req_ready_o});
    else n_pass++;
    ic_req_valid_i = 0; dc_req_valid_i = 0;
  endtask

  task automatic test_ic_latency;
    l2_fixed_en = 1; l2_fixed = {64{8'hA5}};
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_1040;
    ic_q.push_back(line_of(32'h0000_1040));
    @(negedge clk); #1;   // cycle 1
    ic_req_valid_i = 0;
    n_checks++;
    if ({busy_o, l2_req_valid_o, l2_req_we_o, l2_req_addr_o} !== {3'b110, 32'h0000_1040})
      $display("FAIL lat_issue: busy/valid/we/addr=%b%b%b %h want 110 00001040", busy_o, l2_req_valid_o, l2_req_we_o, l2_req_addr_o);
    else n_pass++;
    @(negedge clk); #1;   // cycle 2
    n_checks++;
    if ({l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o} !== 3'b010)
      $display("FAIL lat_wait: got %b want 010", {l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o});
    else n_pass++;
    @(negedge clk); #1;   // cycle 3
    n_checks++;
    if ({ic_resp_valid_o, dc_resp_valid_o} !== 2'b10) $display("FAIL lat_resp: ic/dc valid=%b want 10", {ic_resp_valid_o, dc_resp_valid_o});
    else n_pass++;
    @(negedge clk); #1;   // cycle 4
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL lat_idle: busy=%b want 0", busy_o);
    else n_pass++;
    drain("latency");
    l2_fixed_en = 0;
  endtask

  task automatic test_round_robin;
    int g = 0;
    int n = 0;
    do_reset();
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_2000;
    dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h4000_0100;
    #1;
    while (g < 4 && n < 200) begin
      if (ic_req_ready_o || dc_req_ready_o) begin
        n_checks++;
        if ({dc_req_ready_o, ic_req_ready_o} !== ((g % 2) ? 2'b10 : 2'b01))
          $display("FAIL rr_grant%0d: dc/ic ready=%b want %b", g, {dc_req_ready_o, ic_req_ready_o}, (g % 2) ? 2'b10 : 2'b01);
        else n_pass++;
        if (ic_req_ready_o) ic_q.push_back(line_of(ic_req_addr_i));
        else dc_q.push_back('{we: 1'b0, data: line_of(dc_req_addr_i)});
        g++;
        if (g == 4) begin
          @(posedge clk); #1;
          ic_req_valid_i = 0; dc_req_valid_i = 0;
        end
      end
      @(negedge clk); #1; n++;
    end
    n_checks++;
    if (g != 4) $display("FAIL rr_timeout: got %0d grants want 4", g);
    else n_pass++;
    drain("rr");
  endtask

  task automatic test_dc_writeback;
    int n = 0;
    logic [LW-1:0] wd;
    wd = {16{32'h1234_5678}};
    l2_req_ready_i = 0;
    @(negedge clk);
    dc_req_valid_i = 1; dc_req_we_i = 1; dc_req_addr_i = 32'h8000_0000; dc_req_wdata_i = wd;
    #1;
    while (!dc_req_ready_o && n < 50) begin @(negedge clk); #1; n++; end
    dc_q.push_back('{we: 1'b1, data: '0});
    @(posedge clk); #1;
    dc_req_valid_i = 0; dc_req_wdata_i = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({l2_req_valid_o, l2_req_we_o, owner_o, l2_req_addr_o, l2_req_wdata_o} !== {3'b111, 32'h8000_0000, wd})
        $display("FAIL wb_stall%0d: v/we/own=%b%b%b addr=%h wdata=%h", c, l2_req_valid_o, l2_req_we_o, owner_o, l2_req_addr_o, l2_req_wdata_o);
      else n_pass++;
    end
    l2_req_ready_i = 1;
    drain("wb");
  endtask

  task automatic test_ic_kill;
    l2_resp_valid_i = 0;
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_3100;
    @(negedge clk);        // ISSUE
    ic_req_valid_i = 0;
    @(negedge clk); #1;    // WAIT
    ic_kill_i = 1;
    @(negedge clk); #1;    // still WAIT with drop pending
    ic_kill_i = 0; l2_resp_valid_i = 1;
    #1;
    n_checks++;
    if (l2_resp_ready_o !== 1'b1) $display("FAIL kill_consume: l2_resp_ready=%b want 1", l2_resp_ready_o);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({busy_o, ic_resp_valid_o} !== 2'b00) $display("FAIL kill_idle: busy/ic_valid=%b want 00", {busy_o, ic_resp_valid_o});
    else n_pass++;
    drain("kill");
  endtask

  task automatic test_resp_backpressure;
    int n = 0;
    logic [LW-1:0] e;
    ic_resp_ready_i = 0;
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_3000;
    e = line_of(32'h0000_3000);
    ic_q.push_back(e);
    #1;
    while (!ic_req_ready_o && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    ic_req_valid_i = 0;
    repeat (3) @(negedge clk);   // ISSUE, WAIT, RESP
    dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h5000_0040;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({ic_resp_valid_o, dc_req_ready_o} !== 2'b10 || ic_resp_data_o !== e)
        $display("FAIL bp_hold%0d: ic_valid=%b dc_ready=%b data=%h", c, ic_resp_valid_o, dc_req_ready_o, ic_resp_data_o);
      else n_pass++;
      @(negedge clk);
    end
    ic_resp_ready_i = 1;
    @(negedge clk); #1;
    n_checks++;
    if (dc_req_ready_o !== 1'b1) $display("FAIL bp_release: dc_ready=%b want 1", dc_req_ready_o);
    else n_pass++;
    dc_q.push_back('{we: 1'b0, data: line_of(32'h5000_0040)});
    @(posedge clk); #1;
    dc_req_valid_i = 0;
    drain("bp");
  endtask

  task automatic test_reset_mid;
    l2_resp_valid_i = 0;
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_3200;
    @(negedge clk);
    ic_req_valid_i = 0;
    @(negedge clk);        // WAIT
    rst_i = 1; l2_resp_valid_i = 1;
    #1;
    n_checks++;
    if ({busy_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o} !== 5'b0)
      $display("FAIL rst_mid_valids: got %b want 00000", {busy_o, l2_req_valid_o, l2_resp_ready_o, ic_resp_valid_o, dc_resp_valid_o});
    else n_pass++;
    @(negedge clk);
    rst_i = 0;
    ic_req_valid_i = 1; dc_req_valid_i = 1; dc_req_we_i = 0;
    #1;
    n_checks++;
    if ({ic_req_ready_o, dc_req_ready_o, l2_resp_ready_o} !== 3'b100)
      $display("FAIL rst_mid_tie: ic/dc ready, l2_resp_ready=%b want 100", {ic_req_ready_o, dc_req_ready_o, l2_resp_ready_o});
    else n_pass++;
    ic_req_valid_i = 0; dc_req_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ic_latency();
    test_round_robin();
    test_dc_writeback();
    test_ic_kill();
    test_resp_backpressure();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ic_q.size() != 0 || dc_q.size() != 0) $display("FAIL final_queues: ic_q=%0d dc_q=%0d want 0/0", ic_q.size(), dc_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
